// File: rtl/axil_reg_pkg.sv
// axil_reg_pkg: response codes, FSM state types and byte-merge helper for axil_reg_bank
package axil_reg_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;
  function automatic logic [31:0] strb_merge(input logic [31:0] old, input logic [31:0] data, input logic [3:0] strb);
    strb_merge = old;
    for (int i = 0; i < 4; i++) if (strb[i]) strb_merge[8*i+:8] = data[8*i+:8];
  endfunction
endpackage

// File: rtl/axi_lite.sv
// axi_lite: AXI4-Lite bus bundle with master and slave views
interface axi_lite #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0] awprot;
  logic awvalid, awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic wvalid, wready;
  logic [1:0] bresp;
  logic bvalid, bready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0] arprot;
  logic arvalid, arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0] rresp;
  logic rvalid, rready;
  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    input awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
  modport slave (
    input awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axil_reg_bank.sv
// axil_reg_bank: AXI4-Lite slave exposing RW control registers and RO status registers
module axil_reg_bank
  import axil_reg_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RW = 8,
  parameter int NUM_RO = 8,
  parameter logic [NUM_RW*32-1:0] RST_VAL = '0
) (
  input  logic aclk,
  input  logic aresetn,
  axi_lite.slave s_axil,
  output logic [NUM_RW*32-1:0] ctrl_o,
  output logic [NUM_RW-1:0] ctrl_wr_o,
  input  logic [NUM_RO*32-1:0] stat_i
);
  typedef logic [ADDR_WIDTH-3:0] idx_t;
  if (DATA_WIDTH != 32) begin : g_dw_chk
    $error("axil_reg_bank: DATA_WIDTH must be 32");
  end
  wr_state_t wst, wst_n;
  rd_state_t rdst, rdst_n;
  logic live, aw_held, w_held, aw_hs, w_hs, ar_hs, commit, rd_err;
  idx_t aw_idx, widx, ridx;
  logic [31:0] w_data, wd, rd_val;
  logic [3:0] w_strb, ws;
  logic [NUM_RW-1:0][31:0] ctrl;
  logic unused_ok;
  assign unused_ok = ^{s_axil.awprot, s_axil.arprot, s_axil.awaddr[1:0], s_axil.araddr[1:0]};
  assign ctrl_o = ctrl;
  // live keeps the readies low through reset and releases them one edge later
  always_comb begin
    s_axil.awready = live && wst == W_IDLE && !aw_held;
    s_axil.wready = live && wst == W_IDLE && !w_held;
    s_axil.arready = live && rdst == R_IDLE;
    aw_hs = s_axil.awvalid && s_axil.awready;
    w_hs = s_axil.wvalid && s_axil.wready;
    ar_hs = s_axil.arvalid && s_axil.arready;
    commit = live && wst == W_IDLE && (aw_held || aw_hs) && (w_held || w_hs);
    widx = aw_held ? aw_idx : s_axil.awaddr[ADDR_WIDTH-1:2];
    wd = w_held ? w_data : s_axil.wdata;
    ws = w_held ? w_strb : s_axil.wstrb;
    ridx = s_axil.araddr[ADDR_WIDTH-1:2];
    rd_err = ridx >= idx_t'(NUM_RW + NUM_RO);
    rd_val = '0;
    for (int k = 0; k < NUM_RW; k++) if (ridx == idx_t'(k)) rd_val = ctrl[k];
    for (int k = 0; k < NUM_RO; k++) if (ridx == idx_t'(NUM_RW + k)) rd_val = stat_i[32*k+:32];
    wst_n = commit ? W_RESP : (wst == W_RESP && s_axil.bready) ? W_IDLE : wst;
    rdst_n = ar_hs ? R_DATA : (rdst == R_DATA && s_axil.rready) ? R_IDLE : rdst;
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wst <= W_IDLE;
      rdst <= R_IDLE;
    end else begin
      wst <= wst_n;
      rdst <= rdst_n;
    end
  end
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      live <= 1'b0;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      aw_idx <= '0;
      w_data <= '0;
      w_strb <= '0;
      ctrl <= RST_VAL;
      ctrl_wr_o <= '0;
      s_axil.bvalid <= 1'b0;
      s_axil.bresp <= RESP_OKAY;
      s_axil.rvalid <= 1'b0;
      s_axil.rresp <= RESP_OKAY;
      s_axil.rdata <= '0;
    end else begin
      live <= 1'b1;
      ctrl_wr_o <= '0;
      if (aw_hs) begin
        aw_held <= 1'b1;
        aw_idx <= s_axil.awaddr[ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= s_axil.wdata;
        w_strb <= s_axil.wstrb;
      end
      if (commit) begin
        s_axil.bvalid <= 1'b1;
        s_axil.bresp <= widx < idx_t'(NUM_RW) ? RESP_OKAY : RESP_SLVERR;
        for (int k = 0; k < NUM_RW; k++) begin
          if (widx == idx_t'(k)) begin
            ctrl[k] <= strb_merge(ctrl[k], wd, ws);
            ctrl_wr_o[k] <= 1'b1;
          end
        end
      end else if (wst == W_RESP && s_axil.bready) begin
        s_axil.bvalid <= 1'b0;
        aw_held <= 1'b0;
        w_held <= 1'b0;
      end
      // read data is captured at acceptance so it never sees a same-cycle write
      if (ar_hs) begin
        s_axil.rvalid <= 1'b1;
        s_axil.rdata <= rd_val;
        s_axil.rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (rdst == R_DATA && s_axil.rready) begin
        s_axil.rvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axil_reg_bank.sv
// tb_axil_reg_bank: scoreboard bench for axil_reg_bank with cycle checks on commit timing
module tb_axil_reg_bank;
  localparam logic [255:0] RV = {224'h0, 32'hDEADBEEF};
  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic [255:0] ctrl;
  logic [7:0] ctrl_wr;
  logic [255:0] stat_v = '0;
  logic [31:0] model [8];
  logic [1:0] bq [$];
  logic [33:0] rq [$];
  int checks = 0;
  int fails = 0;
  axi_lite #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
  axil_reg_bank #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_RW(8), .NUM_RO(8), .RST_VAL(RV)) dut (
    .aclk(clk), .aresetn(aresetn), .s_axil(bus), .ctrl_o(ctrl), .ctrl_wr_o(ctrl_wr), .stat_i(stat_v)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [255:0] packed_model();
    logic [255:0] p;
    for (int k = 0; k < 8; k++) p[32*k+:32] = model[k];
    return p;
  endfunction
  function automatic logic [31:0] mask_merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (d & m);
  endfunction
  task automatic model_reset();
    for (int k = 0; k < 8; k++) model[k] = RV[32*k+:32];
  endtask
  always @(negedge clk) begin
    if (aresetn && bus.bvalid && bus.bready) begin
      if (bq.size() == 0) chk("b_unexpected", 1, 0);
      else chk("bresp", bus.bresp, bq.pop_front());
    end
    if (aresetn && bus.rvalid && bus.rready) begin
      if (rq.size() == 0) chk("r_unexpected", 1, 0);
      else chk("rresp_rdata", {bus.rresp, bus.rdata}, rq.pop_front());
    end
  end
  task automatic send_aw(input logic [31:0] a, input int d);
    repeat (d) begin @(posedge clk); #1; end
    bus.awaddr = a;
    bus.awvalid = 1'b1;
    for (int n = 0; n <= 50; n++) begin
      @(negedge clk);
      if (bus.awready) break;
      if (n == 50) chk("aw_timeout", 0, 1);
    end
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
  endtask
  task automatic send_w(input logic [31:0] data, input logic [3:0] s, input int d);
    repeat (d) begin @(posedge clk); #1; end
    bus.wdata = data;
    bus.wstrb = s;
    bus.wvalid = 1'b1;
    for (int n = 0; n <= 50; n++) begin
      @(negedge clk);
      if (bus.wready) break;
      if (n == 50) chk("w_timeout", 0, 1);
    end
    @(posedge clk); #1;
    bus.wvalid = 1'b0;
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] data, input logic [3:0] s, input int da, input int dw);
    int idx;
    logic [7:0] exp_wr;
    idx = int'(a >> 2);
    exp_wr = '0;
    fork
      send_aw(a, da);
      send_w(data, s, dw);
    join
    if (idx < 8) begin
      exp_wr[idx] = 1'b1;
      model[idx] = mask_merge(model[idx], data, s);
      bq.push_back(2'b00);
    end else begin
      bq.push_back(2'b10);
    end
    @(negedge clk);
    chk("bvalid_latency", bus.bvalid, 1);
    chk("ctrl_after_commit", ctrl, packed_model());
    chk("ctrl_wr_pulse", ctrl_wr, exp_wr);
    @(negedge clk);
    chk("ctrl_wr_clear", ctrl_wr, 0);
    @(posedge clk); #1;
  endtask
  task automatic rd(input logic [31:0] a, input int d);
    int idx;
    repeat (d) begin @(posedge clk); #1; end
    idx = int'(a >> 2);
    if (idx < 8) rq.push_back({2'b00, model[idx]});
    else if (idx < 16) rq.push_back({2'b00, stat_v[32*(idx-8)+:32]});
    else rq.push_back({2'b10, 32'h0});
    bus.araddr = a;
    bus.arvalid = 1'b1;
    for (int n = 0; n <= 50; n++) begin
      @(negedge clk);
      if (bus.arready) break;
      if (n == 50) chk("ar_timeout", 0, 1);
    end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
  endtask
  task automatic drain();
    for (int n = 0; n <= 60; n++) begin
      if (bq.size() == 0 && rq.size() == 0) break;
      if (n == 60) chk("drain_timeout", bq.size() + rq.size(), 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask
  initial begin
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b1;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_readies", {bus.awready, bus.wready, bus.arready}, 0);
    chk("rst_valids", {bus.bvalid, bus.rvalid}, 0);
    chk("rst_resp_data", {bus.bresp, bus.rresp, bus.rdata}, 0);
    chk("rst_ctrl0", ctrl[31:0], 32'hDEADBEEF);
    chk("rst_ctrl_all", ctrl, RV);
    chk("rst_ctrl_wr", ctrl_wr, 0);
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);
    @(posedge clk); #1;
    wr(32'h4, 32'h12345678, 4'b0011, 2, 0);
    wr(32'h20, 32'hAAAAAAAA, 4'b1111, 0, 0);
    drain();
    rd(32'h4, 0);
    rd(32'h0, 0);
    rd(32'h100, 0);
    drain();
    wr(32'hC, 32'h0000FFFF, 4'b0000, 0, 0);
    wr(32'h1E, 32'hA5A5A5A5, 4'b1100, 0, 2);
    rd(32'h1C, 0);
    rd(32'hC, 0);
    drain();
    stat_v[63:32] = 32'hCAFE0001;
    bus.rready = 1'b0;
    rd(32'h24, 0);
    stat_v[63:32] = 32'h12345678;
    repeat (5) begin
      @(negedge clk);
      chk("bp_rvalid", bus.rvalid, 1);
      chk("bp_rdata", bus.rdata, 32'hCAFE0001);
    end
    @(posedge clk); #1;
    bus.rready = 1'b1;
    drain();
    wr(32'h0, 32'h0, 4'b1111, 0, 0);
    drain();
    fork
      wr(32'h0, 32'hFFFFFFFF, 4'b1111, 0, 0);
      rd(32'h0, 0);
    join
    drain();
    chk("conc_ctrl0", ctrl[31:0], 32'hFFFFFFFF);
    stat_v[31:0] = 32'h0BADF00D;
    rd(32'h20, 0);
    rd(32'h3C, 0);
    drain();
    send_aw(32'h8, 0);
    aresetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_bvalid", bus.bvalid, 0);
    chk("midrst_readies", {bus.awready, bus.wready, bus.arready}, 0);
    @(posedge clk); #1;
    aresetn = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    chk("midrst_ctrl", ctrl, packed_model());
    chk("midrst_bvalid_after", bus.bvalid, 0);
    chk("midrst_readies_after", {bus.awready, bus.wready, bus.arready}, 3'b111);
    @(posedge clk); #1;
    wr(32'h10, 32'h11223344, 4'b1111, 1, 0);
    rd(32'h10, 0);
    rd(32'h8, 0);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
